artix_spi_slave: RTL and testbench

ARTIX_SPI_SLAVE -- requirements
Module: artix_spi_slave

---
 rtl/artix_spi_pkg.sv | 23 ++
 rtl/spi_sync_edge.sv | 29 ++
 rtl/artix_spi_slave.sv | 235 +++++++++++++++++++++++
 tb/tb_artix_spi_slave.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/artix_spi_pkg.sv
// rtl/artix_spi_pkg.sv - shared state type and frame constants for the SPI register slave
package artix_spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        FETCH,
        DATA,
        ERR
    } spi_state_e;

    localparam int HDR_BITS       = 8;
    localparam int DATA_W_DEFAULT = 32;
    localparam int FRAME_BITS     = HDR_BITS + DATA_W_DEFAULT;

    // R/W is the first header bit shifted in, so it lands in the header MSB
    localparam int RW_BIT_POS = HDR_BITS - 1;

    function automatic int frame_bits_for(input int data_w);
        return HDR_BITS + data_w;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - multi-stage synchronizer with rise/fall detection on its last two stages
module spi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic aclk,
    input  logic aresetn,
    input  logic async_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] stage_q;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            stage_q <= {SYNC_STAGES{RST_VAL}};
        end else begin
            stage_q <= {stage_q[SYNC_STAGES-2:0], async_i};
        end
    end

    // The level reported is the newer of the two compared stages, so it matches the edge strobes
    assign sync_o = stage_q[SYNC_STAGES-2];
    assign rise_o = stage_q[SYNC_STAGES-2] & ~stage_q[SYNC_STAGES-1];
    assign fall_o = ~stage_q[SYNC_STAGES-2] & stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/artix_spi_slave.sv
// rtl/artix_spi_slave.sv - mode-0 SPI slave bridging 8+DATA_W bit frames onto a register read/write port
module artix_spi_slave
    import artix_spi_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int ADDR_W      = 7,
    parameter int DATA_W      = 32
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              spi_sclk,
    input  logic              spi_cs_n,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    output logic              reg_wr_en,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [DATA_W-1:0] reg_wr_data,
    output logic              reg_rd_req,
    input  logic [DATA_W-1:0] reg_rd_data,
    output logic              frame_err,
    output logic [15:0]       frame_cnt,
    output logic [15:0]       err_cnt
);

    localparam int               FRAME_LEN = frame_bits_for(DATA_W);
    localparam int               CNT_W     = $clog2(FRAME_LEN + 2);
    localparam logic [CNT_W-1:0] CNT_HDR   = CNT_W'(HDR_BITS);
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FRAME_LEN);

    logic sclk_lvl, sclk_rise, sclk_fall;
    logic cs_lvl, cs_rise, cs_fall;
    logic [SYNC_STAGES-2:0] mosi_q;
    logic mosi_sync;
    logic [HDR_BITS-1:0] hdr_full;

    spi_state_e          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [HDR_BITS-2:0] hdr_q, hdr_d;
    logic [DATA_W-1:0]   rx_q, rx_d;
    logic [DATA_W-1:0]   tx_q, tx_d;
    logic                rd_q, rd_d;
    logic                fetch_ph_q, fetch_ph_d;
    logic                armed_q, armed_d;
    logic [2:0]          settle_q, settle_d;
    logic                settle_done;
    logic                wr_en_q, wr_en_d;
    logic                ferr_q, ferr_d;
    logic [15:0]         frame_cnt_q, frame_cnt_d;
    logic [15:0]         err_cnt_q, err_cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;

    spi_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .RST_VAL     (1'b0)
    ) u_sclk_sync (
        .aclk    (aclk),
        .aresetn (aresetn),
        .async_i (spi_sclk),
        .sync_o  (sclk_lvl),
        .rise_o  (sclk_rise),
        .fall_o  (sclk_fall)
    );

    spi_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .RST_VAL     (1'b1)
    ) u_cs_sync (
        .aclk    (aclk),
        .aresetn (aresetn),
        .async_i (spi_cs_n),
        .sync_o  (cs_lvl),
        .rise_o  (cs_rise),
        .fall_o  (cs_fall)
    );

    // mosi goes one stage shallower so it lines up with the sclk level the edge detector compares
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            mosi_q <= '0;
        end else begin
            mosi_q[0] <= spi_mosi;
            for (int i = 1; i < SYNC_STAGES - 1; i++) begin
                mosi_q[i] <= mosi_q[i-1];
            end
        end
    end

    assign mosi_sync   = mosi_q[SYNC_STAGES-2];
    assign hdr_full    = {hdr_q, mosi_sync};
    assign settle_done = (settle_q == 3'(SYNC_STAGES));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hdr_d       = hdr_q;
        rx_d        = rx_q;
        tx_d        = tx_q;
        rd_d        = rd_q;
        fetch_ph_d  = 1'b0;
        armed_d     = armed_q;
        settle_d    = settle_q;
        wr_en_d     = 1'b0;
        ferr_d      = 1'b0;
        frame_cnt_d = frame_cnt_q;
        err_cnt_d   = err_cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;

        // A cs_n still low when reset releases must not look like a new frame start
        if (!settle_done) begin
            settle_d = settle_q + 3'd1;
        end
        if (settle_done && cs_lvl && !sclk_lvl) begin
            armed_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (cs_fall && armed_q) begin
                    state_d = HDR;
                    cnt_d   = '0;
                    hdr_d   = '0;
                    rx_d    = '0;
                    tx_d    = '0;
                    rd_d    = 1'b0;
                end
            end
            HDR: begin
                if (sclk_rise) begin
                    hdr_d = hdr_full[HDR_BITS-2:0];
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_d == CNT_HDR) begin
                        addr_d  = ADDR_W'(hdr_full[HDR_BITS-2:0]);
                        rd_d    = hdr_full[RW_BIT_POS];
                        state_d = hdr_full[RW_BIT_POS] ? FETCH : DATA;
                    end
                end
            end
            FETCH: begin
                fetch_ph_d = 1'b1;
                if (fetch_ph_q) begin
                    tx_d       = reg_rd_data;
                    fetch_ph_d = 1'b0;
                    state_d    = DATA;
                end
            end
            DATA: begin
                if (sclk_rise) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_FULL) begin
                        state_d = ERR;
                    end else begin
                        rx_d = {rx_q[DATA_W-2:0], mosi_sync};
                    end
                end else if (sclk_fall && rd_q && (cnt_q > CNT_HDR)) begin
                    // The fall right after the header leaves the MSB in place for the first data rise
                    tx_d = {tx_q[DATA_W-2:0], 1'b0};
                end
            end
            ERR: begin
                state_d = ERR;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Frame close is evaluated after any same-cycle sclk rise has been folded into cnt_d
        if (cs_rise && (state_q != IDLE)) begin
            state_d    = IDLE;
            fetch_ph_d = 1'b0;
            if (cnt_d == CNT_FULL) begin
                frame_cnt_d = frame_cnt_q + 16'd1;
                if (!rd_q) begin
                    wr_en_d = 1'b1;
                    wdata_d = rx_d;
                end
            end else begin
                ferr_d = 1'b1;
                if (err_cnt_q != 16'hFFFF) begin
                    err_cnt_d = err_cnt_q + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            hdr_q       <= '0;
            rx_q        <= '0;
            tx_q        <= '0;
            rd_q        <= 1'b0;
            fetch_ph_q  <= 1'b0;
            armed_q     <= 1'b0;
            settle_q    <= '0;
            wr_en_q     <= 1'b0;
            ferr_q      <= 1'b0;
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hdr_q       <= hdr_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            rd_q        <= rd_d;
            fetch_ph_q  <= fetch_ph_d;
            armed_q     <= armed_d;
            settle_q    <= settle_d;
            wr_en_q     <= wr_en_d;
            ferr_q      <= ferr_d;
            frame_cnt_q <= frame_cnt_d;
            err_cnt_q   <= err_cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
        end
    end

    assign spi_miso    = (state_q == DATA) && rd_q && tx_q[DATA_W-1];
    assign spi_miso_oe = ~cs_lvl;
    assign reg_rd_req  = (state_q == FETCH) && !fetch_ph_q;
    assign reg_wr_en   = wr_en_q;
    assign reg_addr    = addr_q;
    assign reg_wr_data = wdata_q;
    assign frame_err   = ferr_q;
    assign frame_cnt   = frame_cnt_q;
    assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_artix_spi_slave.sv
// tb/tb_artix_spi_slave.sv - randomized scoreboard bench for artix_spi_slave
module tb_artix_spi_slave;

    localparam int ADDR_W = 7;
    localparam int DATA_W = 32;
    localparam int HP     = 6;

    typedef struct packed {
        logic [6:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic              aclk = 1'b0;
    logic              aresetn = 1'b0;
    logic              spi_sclk = 1'b0;
    logic              spi_cs_n = 1'b1;
    logic              spi_mosi = 1'b0;
    logic              spi_miso;
    logic              spi_miso_oe;
    logic              reg_wr_en;
    logic [ADDR_W-1:0] reg_addr;
    logic [DATA_W-1:0] reg_wr_data;
    logic              reg_rd_req;
    logic [DATA_W-1:0] reg_rd_data = '0;
    logic              frame_err;
    logic [15:0]       frame_cnt;
    logic [15:0]       err_cnt;

    int          checks = 0;
    int          errors = 0;
    wr_t         exp_wr[$];
    logic [6:0]  exp_rd[$];
    int          exp_err[$];
    logic [31:0] mem [0:127];
    int          model_frames = 0;
    int          model_errs = 0;

    always #5 aclk = ~aclk;

    artix_spi_slave #(
        .SYNC_STAGES (2),
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W)
    ) dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .spi_sclk    (spi_sclk),
        .spi_cs_n    (spi_cs_n),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .spi_miso_oe (spi_miso_oe),
        .reg_wr_en   (reg_wr_en),
        .reg_addr    (reg_addr),
        .reg_wr_data (reg_wr_data),
        .reg_rd_req  (reg_rd_req),
        .reg_rd_data (reg_rd_data),
        .frame_err   (frame_err),
        .frame_cnt   (frame_cnt),
        .err_cnt     (err_cnt)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Write strobes and error pulses are matched against what the stimulus predicted
    initial begin
        wr_t e;
        forever begin
            @(negedge aclk);
            if (reg_wr_en) begin
                if (exp_wr.size() == 0) begin
                    check("unexpected_write", reg_wr_en, 1'b0);
                end else begin
                    e = exp_wr.pop_front();
                    check("wr_addr", reg_addr, e.addr);
                    check("wr_data", reg_wr_data, e.data);
                end
            end
            if (frame_err) begin
                if (exp_err.size() == 0) begin
                    check("unexpected_frame_err", frame_err, 1'b0);
                end else begin
                    void'(exp_err.pop_front());
                end
            end
        end
    end

    // Register-file responder: read data is valid only in the cycle after the request
    initial begin
        logic [6:0] a;
        forever begin
            @(negedge aclk);
            if (reg_rd_req) begin
                if (exp_rd.size() == 0) begin
                    check("unexpected_rd_req", reg_rd_req, 1'b0);
                end else begin
                    a = exp_rd.pop_front();
                    check("rd_addr", reg_addr, a);
                end
                @(posedge aclk);
                #1 reg_rd_data = mem[reg_addr];
                @(negedge aclk);
                check("rd_req_one_cycle", reg_rd_req, 1'b0);
                @(posedge aclk);
                #1 reg_rd_data = $urandom;
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog");
    end

    // Drives a mode-0 frame and leaves cs_n low after the last sclk fall
    task automatic spi_frame(input bit rd, input logic [6:0] addr, input logic [31:0] data,
                             input int nbits, output logic [31:0] rx);
        logic [39:0] f;
        f  = {rd, addr, data};
        rx = '0;
        spi_cs_n = 1'b0;
        repeat (HP) @(negedge aclk);
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = (i < 40) ? f[39-i] : 1'b0;
            repeat (HP) @(negedge aclk);
            if (i >= 8 && i < 40) rx = {rx[30:0], spi_miso};
            spi_sclk = 1'b1;
            repeat (HP) @(negedge aclk);
            spi_sclk = 1'b0;
        end
        spi_mosi = 1'b0;
    endtask

    task automatic check_counters(input string tag);
        check({tag, "_frame_cnt"}, frame_cnt, 16'(model_frames));
        check({tag, "_err_cnt"}, err_cnt, 16'(model_errs));
        check({tag, "_miso_idle"}, spi_miso, 1'b0);
        check({tag, "_oe_idle"}, spi_miso_oe, 1'b0);
    endtask

    task automatic do_frame(input bit rd, input logic [6:0] addr, input logic [31:0] data,
                            input int nbits, input int gap);
        logic [31:0] got;
        logic [31:0] exp_word;
        exp_word = mem[addr];
        if (rd && nbits >= 8) exp_rd.push_back(addr);
        if (nbits == 40) begin
            model_frames++;
            if (!rd) begin
                exp_wr.push_back({addr, data});
                mem[addr] = data;
            end
        end else begin
            exp_err.push_back(nbits);
            if (model_errs < 65535) model_errs++;
        end
        spi_frame(rd, addr, data, nbits, got);
        repeat (HP) @(negedge aclk);
        if (nbits > 40) check("err_state", dut.state_q, artix_spi_pkg::ERR);
        check("oe_in_frame", spi_miso_oe, 1'b1);
        spi_cs_n = 1'b1;
        repeat (gap) @(negedge aclk);
        if (rd && nbits >= 40) check("miso_word", got, exp_word);
        if (gap >= 8) check_counters("frame");
    endtask

    initial begin
        logic [31:0] dummy;
        int          nb;
        for (int i = 0; i < 128; i++) mem[i] = $urandom;
        mem[16] = 32'hDEADBEEF;

        repeat (5) @(negedge aclk);
        check("rst_wr_en", reg_wr_en, 1'b0);
        check("rst_frame_err", frame_err, 1'b0);
        check("rst_rd_req", reg_rd_req, 1'b0);
        check("rst_miso", spi_miso, 1'b0);
        check("rst_miso_oe", spi_miso_oe, 1'b0);
        check("rst_frame_cnt", frame_cnt, 16'h0);
        check("rst_err_cnt", err_cnt, 16'h0);
        check("rst_addr", reg_addr, 7'h0);
        check("rst_wdata", reg_wr_data, 32'h0);
        aresetn = 1'b1;
        repeat (10) @(negedge aclk);

        do_frame(1'b0, 7'h01, 32'h0000_0003, 40, 8);
        do_frame(1'b0, 7'h02, 32'h0000_0005, 40, 2);
        do_frame(1'b0, 7'h03, 32'h0000_0007, 40, 8);
        do_frame(1'b1, 7'h10, 32'h0, 40, 8);
        do_frame(1'b0, 7'h04, 32'h1234_5678, 20, 8);
        do_frame(1'b0, 7'h05, 32'h8765_4321, 41, 8);
        do_frame(1'b1, 7'h01, 32'h0, 40, 8);

        spi_frame(1'b0, 7'h33, 32'hCAFE_F00D, 12, dummy);
        aresetn = 1'b0;
        repeat (4) @(negedge aclk);
        check("midrst_frame_cnt", frame_cnt, 16'h0);
        check("midrst_err_cnt", err_cnt, 16'h0);
        check("midrst_addr", reg_addr, 7'h0);
        aresetn = 1'b1;
        model_frames = 0;
        model_errs   = 0;
        repeat (8) @(negedge aclk);
        spi_cs_n = 1'b1;
        repeat (8) @(negedge aclk);
        do_frame(1'b0, 7'h44, 32'h0BAD_F00D, 40, 8);

        for (int k = 0; k < 24; k++) begin
            nb = ($urandom_range(0, 9) < 7) ? 40 : int'($urandom_range(0, 43));
            do_frame(1'($urandom_range(0, 1)), 7'($urandom), $urandom, nb, 8);
        end

        repeat (20) @(negedge aclk);
        check("pending_writes", exp_wr.size(), 0);
        check("pending_reads", exp_rd.size(), 0);
        check("pending_errs", exp_err.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
